// File: rtl/c_161_modn_ctrl.sv
// Control stage for a 74LVC161 counter: programmable divide-by-N sequencer with
// start/pause/resume, an optional period target and a completed-period tally.
module c_161_modn_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       mod_n,
  input  logic [CNT_W-1:0] target,
  input  logic [3:0]       Q,
  input  logic             TC,
  output logic             PE,
  output logic             CEP,
  output logic             CET,
  output logic [3:0]       D,
  output logic             period_pulse,
  output logic [CNT_W-1:0] periods,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [3:0]       d_q, d_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] periods_q, periods_d;
  logic [CNT_W-1:0] periods_inc;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             go;
  logic             run_tc;
  logic             target_hit;

  // stop dominates start in every state
  assign go          = start & ~stop;
  assign run_tc      = (state_q == StRun) & TC;
  assign periods_inc = (&periods_q) ? periods_q : periods_q + CNT_W'(1);
  assign target_hit  = (target_q != '0) && (periods_inc == target_q);

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (go) state_d = StLoad;
      StLoad: state_d = StRun;
      StRun: begin
        if (TC && target_hit) begin
          state_d = StIdle;
        end else if (stop) begin
          state_d = StHalt;
        end
      end
      StHalt: if (go) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // PE is the only unregistered output: the reload must land on the TC edge itself
  always_comb begin
    PE = 1'b1;
    case (state_q)
      StLoad:  PE = 1'b0;
      StRun:   PE = ~TC;
      default: PE = 1'b1;
    endcase
  end

  always_comb begin
    d_d       = d_q;
    target_d  = target_q;
    periods_d = periods_q;
    done_d    = done_q;
    pulse_d   = 1'b0;
    if (state_q == StIdle && go) begin
      d_d       = 4'd0 - mod_n;
      target_d  = target;
      periods_d = '0;
      done_d    = 1'b0;
    end
    if (run_tc) begin
      periods_d = periods_inc;
      pulse_d   = 1'b1;
      if (target_hit) done_d = 1'b1;
    end
    en_d   = (state_d == StLoad) || (state_d == StRun);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      d_q       <= 4'd0;
      target_q  <= '0;
      periods_q <= '0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      d_q       <= d_d;
      target_q  <= target_d;
      periods_q <= periods_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
    end
  end

  assign D            = d_q;
  assign CEP          = en_q;
  assign CET          = en_q;
  assign period_pulse = pulse_q;
  assign periods      = periods_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Read-back sanity: the counter's TC must agree with its Q while we run it.
  a_tc_matches_q : assert property (@(posedge CP) disable iff (CR)
    (state_q == StRun) |-> (TC == (Q == 4'hF)));

  a_tc_low_in_halt : assert property (@(posedge CP) disable iff (CR)
    (state_q == StHalt) |-> !TC);

  a_q_held_in_halt : assert property (@(posedge CP) disable iff (CR)
    (state_q == StHalt && $past(state_q) == StHalt && !$past(CR)) |-> $stable(Q));

  a_busy_done_excl : assert property (@(posedge CP) disable iff (CR)
    !(busy && done));

endmodule

// File: tb/tb_c_161_modn_ctrl.sv
// Bench for c_161_modn_ctrl with a behavioural 74LVC161 in the loop; period pulses
// are checked against a scoreboard of expected (cycle, tally) pairs.
module tb_c_161_modn_ctrl;
  localparam int CNT_W = 8;

  logic             CP = 1'b0;
  logic             CR = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [3:0]       mod_n = 4'd0;
  logic [CNT_W-1:0] target = '0;
  logic [3:0]       Q;
  logic             TC;
  logic             PE, CEP, CET;
  logic [3:0]       D;
  logic             period_pulse;
  logic [CNT_W-1:0] periods;
  logic             busy, done;

  typedef struct {
    int         cyc;
    logic [7:0] per;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] cnt_q = 4'd0;
  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;

  c_161_modn_ctrl #(.CNT_W(CNT_W)) dut (
    .CP(CP), .CR(CR), .start(start), .stop(stop), .mod_n(mod_n), .target(target),
    .Q(Q), .TC(TC), .PE(PE), .CEP(CEP), .CET(CET), .D(D), .period_pulse(period_pulse),
    .periods(periods), .busy(busy), .done(done)
  );

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  // 74LVC161 model: synchronous load when PE low, count when CEP & CET
  always @(posedge CP) begin
    if (!PE) cnt_q <= D;
    else if (CEP && CET) cnt_q <= cnt_q + 4'd1;
  end
  assign Q  = cnt_q;
  assign TC = (cnt_q == 4'hF) && CET;

  always @(negedge CP) begin
    if (period_pulse === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected at cycle %0d periods=%0d, none required", cyc, periods);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.per !== periods) begin
          errors++;
          $display("FAIL pulse got cycle %0d periods=%0d, want cycle %0d periods=%0d",
                   cyc, periods, mon_e.cyc, mon_e.per);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic do_reset();
    CR = 1'b1; start = 1'b0; stop = 1'b0;
    #2;
    CR = 1'b0;
    tick(1);
  endtask

  task automatic sb_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d pulses outstanding, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    tick(2);
    vectors++; if (PE !== 1'b1) begin errors++; $display("FAIL rst_pe got %b want 1", PE); end
    vectors++; if (CEP !== 1'b0 || CET !== 1'b0) begin
      errors++; $display("FAIL rst_ce got %b%b want 00", CEP, CET); end
    vectors++; if (D !== 4'd0) begin errors++; $display("FAIL rst_d got %0d want 0", D); end
    vectors++; if (periods !== '0 || period_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_per got %0d/%b want 0/0", periods, period_pulse); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_bd got %b%b want 00", busy, done); end
    CR = 1'b0;
    tick(2);
    vectors++; if (busy !== 1'b0 || PE !== 1'b1) begin
      errors++; $display("FAIL rst_idle got busy=%b pe=%b want 0/1", busy, PE); end
  endtask

  task automatic test_divide5();
    int e;
    e = cyc;
    for (int j = 1; j <= 5; j++) sb.push_back('{e + 2 + 5 * j, 8'(j)});
    mod_n = 4'd5; target = '0; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (D !== 4'd11 || PE !== 1'b0 || CEP !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL div5_load got d=%0d pe=%b cep=%b busy=%b want 11/0/1/1",
                         D, PE, CEP, busy); end
    tick(1);
    for (int m = 0; m <= 25; m++) begin
      vectors++;
      if (Q !== 4'(11 + m % 5)) begin
        errors++; $display("FAIL div5_q step %0d got %0d want %0d", m, Q, 11 + m % 5);
      end
      if (m < 25) tick(1);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge CP);
    #1;
    CR = 1'b1;
    #1;
    vectors++; if (PE !== 1'b1 || CEP !== 1'b0 || CET !== 1'b0) begin
      errors++; $display("FAIL mid_ctl got pe=%b cep=%b cet=%b want 1/0/0", PE, CEP, CET); end
    vectors++; if (periods !== '0 || busy !== 1'b0 || period_pulse !== 1'b0) begin
      errors++; $display("FAIL mid_out got per=%0d busy=%b pulse=%b want 0/0/0",
                         periods, busy, period_pulse); end
    sb_empty("div5");
    tick(2);
    CR = 1'b0;
    tick(3);
    vectors++; if (busy !== 1'b0 || PE !== 1'b1 || CEP !== 1'b0 || Q !== 4'd11) begin
      errors++; $display("FAIL mid_after got busy=%b pe=%b cep=%b q=%0d want 0/1/0/11",
                         busy, PE, CEP, Q); end
  endtask

  task automatic test_target();
    int e;
    e = cyc;
    for (int j = 1; j <= 4; j++) sb.push_back('{e + 2 + 3 * j, 8'(j)});
    mod_n = 4'd3; target = 8'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (D !== 4'd13) begin errors++; $display("FAIL tgt_d got %0d want 13", D); end
    tick(1);
    vectors++; if (Q !== 4'd13) begin errors++; $display("FAIL tgt_q0 got %0d want 13", Q); end
    tick(12);
    vectors++; if (busy !== 1'b0 || done !== 1'b1 || CEP !== 1'b0 || CET !== 1'b0) begin
      errors++; $display("FAIL tgt_end got busy=%b done=%b ce=%b%b want 0/1/00",
                         busy, done, CEP, CET); end
    vectors++; if (periods !== 8'd4 || Q !== 4'd13) begin
      errors++; $display("FAIL tgt_cnt got per=%0d q=%0d want 4/13", periods, Q); end
    tick(6);
    vectors++; if (Q !== 4'd13 || done !== 1'b1) begin
      errors++; $display("FAIL tgt_hold got q=%0d done=%b want 13/1", Q, done); end
    sb_empty("tgt");
  endtask

  task automatic test_pause();
    int e;
    e = cyc;
    mod_n = 4'd0; target = '0; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (done !== 1'b0 || D !== 4'd0) begin
      errors++; $display("FAIL pause_start got done=%b d=%0d want 0/0", done, D); end
    tick(7);
    vectors++; if (Q !== 4'd6) begin errors++; $display("FAIL pause_q6 got %0d want 6", Q); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (Q !== 4'd7 || TC !== 1'b0) begin
        errors++; $display("FAIL pause_hold %0d got q=%0d tc=%b want 7/0", i, Q, TC);
      end
      tick(1);
    end
    vectors++; if (periods !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL pause_st got per=%0d busy=%b want 0/1", periods, busy); end
    sb.push_back('{e + 29, 8'd1});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int m = 1; m <= 9; m++) begin
      tick(1);
      vectors++;
      if (Q !== 4'(7 + m)) begin
        errors++; $display("FAIL resume_q step %0d got %0d want %0d", m, Q, (7 + m) % 16);
      end
    end
    stop = 1'b1;
    tick(1);
    start = 1'b1;
    tick(3);
    vectors++; if (Q !== 4'd1 || busy !== 1'b1 || CEP !== 1'b0 || periods !== 8'd1) begin
      errors++; $display("FAIL halt_both got q=%0d busy=%b cep=%b per=%0d want 1/1/0/1",
                         Q, busy, CEP, periods); end
    sb_empty("pause");
    do_reset();
  endtask

  task automatic test_back_to_back();
    int e;
    e = cyc;
    for (int j = 1; j <= 8; j++) sb.push_back('{e + 2 + j, 8'(j)});
    mod_n = 4'd1; target = '0; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (D !== 4'd15) begin errors++; $display("FAIL b2b_d got %0d want 15", D); end
    tick(1);
    vectors++; if (Q !== 4'd15 || TC !== 1'b1 || PE !== 1'b0) begin
      errors++; $display("FAIL b2b_run got q=%0d tc=%b pe=%b want 15/1/0", Q, TC, PE); end
    tick(8);
    @(negedge CP);
    #1;
    vectors++; if (periods !== 8'd8) begin
      errors++; $display("FAIL b2b_per got %0d want 8", periods); end
    sb_empty("b2b");
    do_reset();
    mod_n = 4'd6; start = 1'b1; stop = 1'b1;
    tick(3);
    vectors++; if (busy !== 1'b0 || PE !== 1'b1 || CEP !== 1'b0 || D !== 4'd0) begin
      errors++; $display("FAIL idle_both got busy=%b pe=%b cep=%b d=%0d want 0/1/0/0",
                         busy, PE, CEP, D); end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_resample();
    int e;
    e = cyc;
    sb.push_back('{e + 6, 8'd1});
    sb.push_back('{e + 14, 8'd2});
    sb.push_back('{e + 18, 8'd3});
    sb.push_back('{e + 22, 8'd4});
    mod_n = 4'd4; target = '0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    mod_n = 4'd9;
    tick(5);
    vectors++; if (Q !== 4'd14) begin errors++; $display("FAIL rs_q14 got %0d want 14", Q); end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    vectors++; if (Q !== 4'd15 || TC !== 1'b0) begin
      errors++; $display("FAIL rs_halt got q=%0d tc=%b want 15/0", Q, TC); end
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    vectors++; if (Q !== 4'd12 || D !== 4'd12) begin
      errors++; $display("FAIL rs_reload got q=%0d d=%0d want 12/12", Q, D); end
    tick(8);
    @(negedge CP);
    #1;
    vectors++; if (periods !== 8'd4) begin
      errors++; $display("FAIL rs_per got %0d want 4", periods); end
    sb_empty("rs");
    do_reset();
    e = cyc;
    sb.push_back('{e + 14, 8'd1});
    sb.push_back('{e + 26, 8'd2});
    mod_n = 4'd12; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (D !== 4'd4) begin errors++; $display("FAIL m12_d got %0d want 4", D); end
    tick(1);
    vectors++; if (Q !== 4'd4) begin errors++; $display("FAIL m12_q got %0d want 4", Q); end
    tick(24);
    @(negedge CP);
    #1;
    vectors++; if (periods !== 8'd2) begin
      errors++; $display("FAIL m12_per got %0d want 2", periods); end
    sb_empty("m12");
    do_reset();
  endtask

  initial begin
    test_reset();
    test_divide5();
    test_reset_midrun();
    test_target();
    test_pause();
    test_back_to_back();
    test_resample();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/c_161_modn_ctrl.md
Name: c_161_modn_ctrl

Overview:
- Control stage that sits directly upstream of a C_74LVC161 4-bit counter. It drives the counter's PE, CEP, CET and D inputs and reads back its Q and TC outputs.
- Together with the counter it forms a programmable divide-by-N / N-period sequencer. It supports start, pause and resume, and an optional period target after which it stops.
- It emits a one-cycle pulse each time the counter completes N states, and tallies completed periods.
- The counter's own active-low CR is driven elsewhere, not by this block.

Parameters:
- CNT_W, 8, width of the period target and period tally.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- CR  input  1  reset, asynchronous, active-high.
- start  input  1  level; request run (from IDLE: load and run; from HALT: resume).
- stop  input  1  level; request pause (RUN -> HALT).
- mod_n  input  4  divide ratio; 0 means 16. Sampled only on start from IDLE.
- target  input  CNT_W  number of periods to run; 0 means free-run. Sampled with mod_n.
- Q  input  4  counter output, read back.
- TC  input  1  counter terminal count (Q==15 & CET).
- PE  output  1  counter parallel-load enable, active-low.
- CEP  output  1  counter count enable.
- CET  output  1  counter count enable, also gates TC.
- D  output  4  counter preload value.
- period_pulse  output  1  one-cycle pulse per completed period.
- periods  output  CNT_W  completed-period tally.
- busy  output  1  high in LOAD, RUN and HALT.
- done  output  1  high in IDLE after a target run completes; cleared on next start.

Behaviour:
- States: IDLE, LOAD, RUN, HALT. Encoding is free.
- Reset (CR=1, async): state=IDLE, D=0, PE=1, CEP=0, CET=0, period_pulse=0, periods=0, busy=0, done=0. Effect is immediate, mid-run included, and there is no drain.
- Preload: D = (16 - mod_n) mod 16, registered on the IDLE->LOAD edge and held until the next IDLE start.
  - mod_n=0 gives D=0, period 16.
  - mod_n=1 gives D=15, period 1: TC is high every RUN cycle and pulses are back-to-back.
- IDLE:
  - CEP=CET=0, PE=1.
  - If start=1 and stop=0: latch N and target, clear periods and done, go to LOAD.
- LOAD:
  - PE=0, CEP=CET=1. The next edge loads D into the counter; the state goes to RUN unconditionally.
  - stop is ignored in LOAD.
- RUN:
  - CEP=CET=1.
  - PE = ~TC, combinational from the TC input. On the edge where TC=1, the counter reloads D instead of wrapping, giving exactly N states per period (D..15).
  - On each edge with TC=1:
    - periods increments (saturates at all-ones).
    - period_pulse=1 for the following cycle.
  - If target!=0 and the incremented periods equals target: go to IDLE and set done=1. This takes priority over stop.
  - Otherwise, if stop=1: go to HALT. The reload/pulse for that edge still occurs if TC=1.
- HALT:
  - CEP=CET=0 and PE=1, so the counter holds Q and TC is forced low.
  - If start=1 and stop=0: go to RUN with no reload. Counting resumes from the held Q.
- start and stop both high: stop wins in every state. IDLE stays IDLE; HALT stays HALT.
- Latency:
  - start seen at edge k: counter holds D after edge k+1.
  - First period_pulse is high in the cycle after edge k+1+N.
- Q is read only for optional assertions. Control uses TC alone.
- All outputs except PE are registered. PE is combinational from the state and TC only.

Test Plan:
- Reset mid-run: mod_n=5, target=0, running; assert CR between edges -> PE=1, CEP=CET=0, periods=0 and busy=0 immediately; after release, state stays IDLE.
- Divide-by-5 free run: mod_n=5, target=0, one start pulse -> D=11; Q sequence 11,12,13,14,15,11,...; period_pulse once every 5 cycles; periods increments 1,2,3...
- Target stop: mod_n=3, target=4 -> exactly 4 period_pulses (Q=13,14,15 repeating); then busy=0, done=1, CEP=CET=0, periods=4, Q frozen at 13.
- Pause/resume: mod_n=0, stop at Q=7 -> Q holds 7 and TC=0 for 10 cycles; start -> Q continues 8..15 then reloads 0; periods unaffected by the pause.
- Edge ratios: mod_n=1 -> D=15, period_pulse high every cycle in RUN. start and stop asserted together in IDLE -> no state change, PE stays 1.
- Resample: change mod_n during RUN and resume from HALT -> ratio unchanged; a fresh start from IDLE with mod_n=12 -> D=4, period 12.
